// File: rtl/cv32e40p_core_v_xif_pkg.sv
// CV-X-IF types shared by the core-side offload controller.
// Holds the X_OFFLOAD_SB_CHECK_EN-independent state and scoreboard types.
package cv32e40p_core_v_xif_pkg;

  localparam int X_ID_W = 4;
  localparam int X_OFFLOAD_MAX_OUTSTANDING = 4;

  typedef struct packed {
    logic [31:0]       instr;
    logic [1:0][31:0]  rs;
    logic [1:0]        rs_valid;
    logic [X_ID_W-1:0] id;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_W-1:0] id;
    logic              commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_W-1:0] id;
    logic [31:0]       data;
    logic [4:0]        rd;
    logic              we;
  } x_result_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COMMIT
  } x_offload_state_e;

  typedef struct packed {
    logic pending;
    logic writeback;
  } sb_entry_t;

endpackage

// File: rtl/cv32e40p_x_scoreboard.sv
// Per-ID pending/writeback tracking and outstanding counter
// for offloaded instructions.
module cv32e40p_x_scoreboard
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_set,
  input  logic [ID_W-1:0] i_set_id,
  input  logic            i_set_wb,
  input  logic            i_kill_clr,
  input  logic [ID_W-1:0] i_kill_id,
  input  logic            i_res_clr,
  input  logic [ID_W-1:0] i_res_id,
  output logic            o_full,
  output logic            o_set_busy,
  output logic            o_res_hit
);

  localparam int N  = 2**ID_W;
  localparam int CW = $clog2(MAX_OUT + 1);

  sb_entry_t     r_sb [N];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_dec;
  logic          w_dup;
  logic [N-1:0]  w_unused_wb;

  // A result and a commit-kill for the same id retire one entry.
  assign w_dup = i_kill_clr && i_res_clr && (i_kill_id == i_res_id);

  always_comb begin
    w_dec = CW'(i_kill_clr) + CW'(i_res_clr) - CW'(w_dup);
  end

  always_comb begin
    w_unused_wb = '0;
    for (int i = 0; i < N; i++) begin
      w_unused_wb[i] = r_sb[i].writeback;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_sb[i] <= '0;
      end
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i_kill_clr && i_kill_id == ID_W'(i)) begin
          r_sb[i] <= '0;
        end
        if (i_res_clr && i_res_id == ID_W'(i)) begin
          r_sb[i] <= '0;
        end
        if (i_set && i_set_id == ID_W'(i)) begin
          r_sb[i] <= {1'b1, i_set_wb};
        end
      end
      r_cnt <= r_cnt + CW'(i_set) - w_dec;
    end
  end

  assign o_full     = (r_cnt == CW'(MAX_OUT));
  assign o_set_busy = r_sb[i_set_id].pending;
  assign o_res_hit  = r_sb[i_res_id].pending;

endmodule

// File: rtl/cv32e40p_x_offload_ctrl.sv
// CV-X-IF initiator: issue/commit/result sequencing for the EX stage.
// X_OFFLOAD_SB_CHECK_EN enables result-ID checking and the ID reuse guard.
module cv32e40p_x_offload_ctrl
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int X_ID_WIDTH      = X_ID_W,
  parameter int MAX_OUTSTANDING = X_OFFLOAD_MAX_OUTSTANDING
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ex_valid_i,
  output logic          ex_ready_o,
  input  logic [31:0]   ex_instr_i,
  input  logic [31:0]   ex_rs1_i,
  input  logic [31:0]   ex_rs2_i,
  input  logic [1:0]    ex_rs_valid_i,
  input  logic          ex_kill_i,
  output logic          illegal_instr_o,
  output logic          x_issue_valid_o,
  input  logic          x_issue_ready_i,
  output x_issue_req_t  x_issue_req_o,
  input  x_issue_resp_t x_issue_resp_i,
  output logic          x_commit_valid_o,
  output x_commit_t     x_commit_o,
  input  logic          x_result_valid_i,
  output logic          x_result_ready_o,
  input  x_result_t     x_result_i,
  output logic          wb_we_o,
  output logic [4:0]    wb_waddr_o,
  output logic [31:0]   wb_wdata_o,
  input  logic          wb_ready_i,
  output logic          err_o
);

  x_offload_state_e        r_state;
  x_offload_state_e        w_state_n;
  logic [X_ID_WIDTH-1:0]   r_id;
  logic [X_ID_WIDTH-1:0]   r_cid;
  logic                    r_kill;
  logic                    r_ckill;
  logic                    r_accept;
  logic                    r_wb_we;
  logic [4:0]              r_wb_waddr;
  logic [31:0]             r_wb_wdata;
  logic                    w_full;
  logic                    w_id_busy;
  logic                    w_res_hit;
  logic                    w_issue_hs;
  logic                    w_res_hs;
  logic                    w_res_ok;
  logic                    w_blocked;
  logic                    w_kill_clr;

  assign w_issue_hs       = (r_state == ISSUE) && x_issue_ready_i;
  assign w_res_hs         = x_result_valid_i && wb_ready_i;
  assign x_result_ready_o = wb_ready_i;

`ifdef X_OFFLOAD_SB_CHECK_EN
  logic r_err;
  assign w_blocked = w_full || w_id_busy;
  assign w_res_ok  = w_res_hs && w_res_hit;
  assign err_o     = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_res_hs && !w_res_hit) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused_chk;
  assign w_blocked    = w_full;
  assign w_res_ok     = w_res_hs;
  assign err_o        = 1'b0;
  assign w_unused_chk = w_id_busy ^ w_res_hit;
`endif

  // Accepted but killed: no result will come, retire it at commit.
  assign w_kill_clr = (r_state == COMMIT) && r_accept
                    && (r_ckill || ex_kill_i);

  cv32e40p_x_scoreboard #(
    .ID_W    (X_ID_WIDTH),
    .MAX_OUT (MAX_OUTSTANDING)
  ) u_sb (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_set      (w_issue_hs && x_issue_resp_i.accept),
    .i_set_id   (r_id),
    .i_set_wb   (x_issue_resp_i.writeback),
    .i_kill_clr (w_kill_clr),
    .i_kill_id  (r_cid),
    .i_res_clr  (w_res_ok),
    .i_res_id   (x_result_i.id),
    .o_full     (w_full),
    .o_set_busy (w_id_busy),
    .o_res_hit  (w_res_hit)
  );

  always_comb begin
    w_state_n        = r_state;
    ex_ready_o       = 1'b0;
    illegal_instr_o  = 1'b0;
    x_issue_valid_o  = 1'b0;
    x_issue_req_o    = '0;
    x_commit_valid_o = 1'b0;
    x_commit_o       = '0;
    unique case (r_state)
      IDLE: begin
        if (ex_valid_i) begin
          if (ex_kill_i) begin
            ex_ready_o = 1'b1;
          end else if (!w_blocked) begin
            w_state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        x_issue_valid_o        = 1'b1;
        x_issue_req_o.instr    = ex_instr_i;
        x_issue_req_o.rs[0]    = ex_rs1_i;
        x_issue_req_o.rs[1]    = ex_rs2_i;
        x_issue_req_o.rs_valid = ex_rs_valid_i;
        x_issue_req_o.id       = r_id;
        if (x_issue_ready_i) begin
          w_state_n = COMMIT;
        end
      end
      COMMIT: begin
        x_commit_valid_o       = 1'b1;
        x_commit_o.id          = r_cid;
        x_commit_o.commit_kill = r_ckill || ex_kill_i || !r_accept;
        ex_ready_o             = 1'b1;
        illegal_instr_o        = !r_accept && !r_ckill;
        w_state_n              = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_id       <= '0;
      r_cid      <= '0;
      r_kill     <= 1'b0;
      r_ckill    <= 1'b0;
      r_accept   <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_waddr <= '0;
      r_wb_wdata <= '0;
    end else begin
      r_state <= w_state_n;
      r_wb_we <= w_res_ok && x_result_i.we;
      if (w_res_ok && x_result_i.we) begin
        r_wb_waddr <= x_result_i.rd;
        r_wb_wdata <= x_result_i.data;
      end
      // Valid may not drop once raised; a kill is remembered instead.
      if (r_state == ISSUE) begin
        if (x_issue_ready_i) begin
          r_kill   <= 1'b0;
          r_ckill  <= r_kill || ex_kill_i;
          r_accept <= x_issue_resp_i.accept;
          r_cid    <= r_id;
          r_id     <= r_id + X_ID_WIDTH'(1);
        end else if (ex_kill_i) begin
          r_kill <= 1'b1;
        end
      end
    end
  end

  assign wb_we_o    = r_wb_we;
  assign wb_waddr_o = r_wb_waddr;
  assign wb_wdata_o = r_wb_wdata;

endmodule
